// File: rtl/control_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : control_pipe_pkg
// Purpose : Shared constants for the control pipeline. Holds the control-word
//           width, control-word bit positions, the RegDest/branchSrc
//           encodings, the opcode/funct values and the FSM state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package control_pipe_pkg;

    localparam int CTRL_W = 10;
    localparam int OP_W   = 6;

    // Control word layout
    localparam int BIT_BRSRC_HI  = 9;
    localparam int BIT_BRSRC_LO  = 8;
    localparam int BIT_ALUSRC    = 7;
    localparam int BIT_REGDST_HI = 6;
    localparam int BIT_REGDST_LO = 5;
    localparam int BIT_MEMREAD   = 4;
    localparam int BIT_MEMWRITE  = 3;
    localparam int BIT_BRANCH    = 2;
    localparam int BIT_REGWRITE  = 1;
    localparam int BIT_MEMTOREG  = 0;

    // branchSrc encodings
    localparam logic [1:0] BRSRC_PCREL = 2'b00;
    localparam logic [1:0] BRSRC_JUMP  = 2'b01;
    localparam logic [1:0] BRSRC_REG   = 2'b10;

    // RegDest encodings
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b11;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct values
    localparam logic [5:0] FN_JR = 6'b001000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage : control_pipe_pkg
`default_nettype wire

// File: rtl/control_pipe_decode.sv
`default_nettype none
// ============================================================================
// Module  : control_decode
// Purpose : Purely combinational opcode/funct to control-word decoder with an
//           illegal-opcode flag. Unknown opcodes produce an all-zero word.
// Ports   : opcode_i  - ID-stage opcode
//           funct_i   - ID-stage funct field (R-type only)
//           ctrl_o    - decoded control word
//           illegal_o - opcode not recognised
// Revision: 1.0 - initial release
// ============================================================================
module control_decode
    import control_pipe_pkg::*;
#(
    parameter int CONTROL_SIZE = CTRL_W,
    parameter int OPCODE_WIDTH = OP_W
) (
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic [OPCODE_WIDTH-1:0] funct_i,
    output logic [CONTROL_SIZE-1:0] ctrl_o,
    output logic                    illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_JR) begin
                    ctrl_o[BIT_BRSRC_HI:BIT_BRSRC_LO] = BRSRC_REG;
                    ctrl_o[BIT_BRANCH]                = 1'b1;
                end else begin
                    ctrl_o[BIT_ALUSRC]                  = 1'b1;
                    ctrl_o[BIT_REGDST_HI:BIT_REGDST_LO] = REGDST_RD;
                    ctrl_o[BIT_REGWRITE]                = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_o[BIT_REGDST_HI:BIT_REGDST_LO] = REGDST_RT;
                ctrl_o[BIT_MEMREAD]                 = 1'b1;
                ctrl_o[BIT_REGWRITE]                = 1'b1;
                ctrl_o[BIT_MEMTOREG]                = 1'b1;
            end
            OP_SW: begin
                ctrl_o[BIT_MEMWRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o[BIT_BRSRC_HI:BIT_BRSRC_LO] = BRSRC_PCREL;
                ctrl_o[BIT_ALUSRC]                = 1'b1;
                ctrl_o[BIT_BRANCH]                = 1'b1;
            end
            OP_J: begin
                ctrl_o[BIT_BRSRC_HI:BIT_BRSRC_LO] = BRSRC_JUMP;
                ctrl_o[BIT_BRANCH]                = 1'b1;
            end
            OP_JAL: begin
                // Link into $31
                ctrl_o[BIT_BRSRC_HI:BIT_BRSRC_LO]   = BRSRC_JUMP;
                ctrl_o[BIT_BRANCH]                  = 1'b1;
                ctrl_o[BIT_REGWRITE]                = 1'b1;
                ctrl_o[BIT_REGDST_HI:BIT_REGDST_LO] = REGDST_RA;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                ctrl_o[BIT_REGDST_HI:BIT_REGDST_LO] = REGDST_RT;
                ctrl_o[BIT_REGWRITE]                = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule : control_decode
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module  : control_pipe
// Purpose : Decodes the ID instruction into a 10-bit control word and carries
//           it through ID/EX, EX/MEM and MEM/WB control registers. Sequences
//           jump/branch holds: after an accepted jump the PC is held for
//           JUMP_DELAY cycles while bubbles enter ID/EX.
//           Build option DELAY_SLOT_EN: the first HOLD cycle decodes the ID
//           instruction (delay slot); a jump/branch in that slot is zeroed and
//           flagged as illegal.
// Ports   : clock     - rising-edge clock
//           reset     - asynchronous active-low reset
//           opcode    - ID-stage opcode
//           funct     - ID-stage funct field
//           stall     - load-use stall from hazard detection
//           exCtrl    - ID/EX control bits [9:5]
//           memCtrl   - EX/MEM control bits [4:2]
//           wbCtrl    - MEM/WB control bits [1:0]
//           isJump    - ID instruction is an accepted jump/branch
//           pcHold    - freeze PC/IF while in HOLD
//           illegalOp - registered illegal-opcode flag
// Revision: 1.0 - initial release
// ============================================================================
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int CONTROL_SIZE = CTRL_W,
    parameter int OPCODE_WIDTH = OP_W,
    parameter int JUMP_DELAY   = 2      // legal range 1..7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [OPCODE_WIDTH-1:0] funct,
    input  logic                    stall,
    output logic [4:0]              exCtrl,
    output logic [2:0]              memCtrl,
    output logic [1:0]              wbCtrl,
    output logic                    isJump,
    output logic                    pcHold,
    output logic                    illegalOp
);

    localparam logic [2:0] HOLD_INIT = 3'(JUMP_DELAY - 1);

    state_e                  state_q, state_d;
    logic [2:0]              hold_cnt_q, hold_cnt_d;
    logic [CONTROL_SIZE-1:0] idex_q, idex_d;
    logic [4:0]              exmem_q;
    logic [1:0]              memwb_q;
    logic                    illegal_q, illegal_d;

    logic [CONTROL_SIZE-1:0] dec_ctrl;
    logic                    dec_illegal;
    logic                    dec_branch;
    logic                    in_slot;

    control_decode #(
        .CONTROL_SIZE (CONTROL_SIZE),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign dec_branch = dec_ctrl[BIT_BRANCH];

`ifdef DELAY_SLOT_EN
    // The counter still holds its load value only in the first HOLD cycle.
    assign in_slot = (state_q == ST_HOLD) && (hold_cnt_q == HOLD_INIT);
`else
    assign in_slot = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        idex_d     = '0;
        illegal_d  = 1'b0;
        isJump     = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A stalled instruction is re-decoded next cycle, so nothing
                // about it is committed now (bubble, no jump, no flag).
                if (!stall) begin
                    idex_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    if (dec_branch) begin
                        isJump     = 1'b1;
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_INIT;
                    end
                end
            end
            ST_HOLD: begin
                if (in_slot) begin
                    if (dec_branch) begin
                        illegal_d = 1'b1;
                    end else begin
                        idex_d    = dec_ctrl;
                        illegal_d = dec_illegal;
                    end
                end
                if (hold_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= 3'd0;
            idex_q     <= '0;
            exmem_q    <= '0;
            memwb_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            idex_q     <= idex_d;
            exmem_q    <= idex_q[4:0];
            memwb_q    <= exmem_q[1:0];
            illegal_q  <= illegal_d;
        end
    end

    assign exCtrl    = idex_q[9:5];
    assign memCtrl   = exmem_q[4:2];
    assign wbCtrl    = memwb_q;
    assign pcHold    = (state_q == ST_HOLD);
    assign illegalOp = illegal_q;

endmodule : control_pipe
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_pipe
// Purpose : Directed self-checking bench for control_pipe (JUMP_DELAY=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_control_pipe;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       stall;
    logic [4:0] exCtrl;
    logic [2:0] memCtrl;
    logic [1:0] wbCtrl;
    logic       isJump;
    logic       pcHold;
    logic       illegalOp;

    int checks;
    int failures;

    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] JRF  = 6'b001000;

    control_pipe #(
        .CONTROL_SIZE (10),
        .OPCODE_WIDTH (6),
        .JUMP_DELAY   (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .stall     (stall),
        .exCtrl    (exCtrl),
        .memCtrl   (memCtrl),
        .wbCtrl    (wbCtrl),
        .isJump    (isJump),
        .pcHold    (pcHold),
        .illegalOp (illegalOp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic st);
        opcode = op;
        funct  = fn;
        stall  = st;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        opcode   = RT;
        funct    = ADD;
        stall    = 1'b0;
        tick();
        tick();
        chk("rst_ex",   10'(exCtrl),    10'h0);
        chk("rst_mem",  10'(memCtrl),   10'h0);
        chk("rst_wb",   10'(wbCtrl),    10'h0);
        chk("rst_hold", 10'(pcHold),    10'h0);
        chk("rst_ill",  10'(illegalOp), 10'h0);

        // LW / ADDI / SW / R-type stream
        reset = 1'b1;
        drive(LW, ADD, 1'b0);
        tick();
        chk("lw_ex", 10'(exCtrl), 10'b00000);
        drive(ADDI, ADD, 1'b0);
        tick();
        chk("lw_mem", 10'(memCtrl), 10'b100);
        drive(SW, ADD, 1'b0);
        tick();
        chk("lw_wb",   10'(wbCtrl),  10'b11);
        chk("addi_mem", 10'(memCtrl), 10'b000);
        drive(RT, ADD, 1'b0);
        tick();
        chk("r_ex",    10'(exCtrl),  10'b00101);
        chk("sw_mem",  10'(memCtrl), 10'b010);
        chk("addi_wb", 10'(wbCtrl),  10'b10);

        // LW then ADDI stalled one cycle
        drive(LW, ADD, 1'b0);
        tick();
        drive(ADDI, ADD, 1'b1);
        chk("stall_nojump", 10'(isJump), 10'h0);
        tick();
        chk("stall_ex",  10'(exCtrl),  10'b00000);
        chk("stall_mem", 10'(memCtrl), 10'b100);
        drive(ADDI, ADD, 1'b0);
        tick();
        chk("stall_mem_bubble", 10'(memCtrl), 10'b000);
        chk("stall_lw_wb",      10'(wbCtrl),  10'b11);
        drive(RT, ADD, 1'b0);
        tick();
        chk("stall_wb_bubble", 10'(wbCtrl), 10'b00);
        tick();
        chk("stall_addi_wb", 10'(wbCtrl), 10'b10);

        // J with JUMP_DELAY=2; a second J in HOLD is squashed
        drive(J, ADD, 1'b0);
        chk("j_isjump", 10'(isJump), 10'h1);
        tick();
        chk("j_ex",    10'(exCtrl), 10'b01000);
        chk("j_hold1", 10'(pcHold), 10'h1);
        drive(RT, ADD, 1'b0);
        chk("j_hold_nojump", 10'(isJump), 10'h0);
        tick();
        chk("j_mem",   10'(memCtrl), 10'b001);
        chk("j_hold2", 10'(pcHold),  10'h1);
`ifdef DELAY_SLOT_EN
        chk("j_slot_ex", 10'(exCtrl), 10'b00101);
`else
        chk("j_bubble1", 10'(exCtrl), 10'b00000);
`endif
        drive(J, ADD, 1'b1);
        chk("j_squash", 10'(isJump), 10'h0);
        tick();
        chk("j_bubble2", 10'(exCtrl), 10'b00000);
        chk("j_release", 10'(pcHold), 10'h0);
        drive(RT, ADD, 1'b0);
        tick();
        chk("j_after_ex", 10'(exCtrl), 10'b00101);

        // BEQ with stall, then accepted
        drive(BEQ, ADD, 1'b1);
        chk("beq_stall_nojump", 10'(isJump), 10'h0);
        tick();
        chk("beq_stall_nohold", 10'(pcHold), 10'h0);
        chk("beq_stall_ex",     10'(exCtrl), 10'b00000);
        drive(BEQ, ADD, 1'b0);
        chk("beq_isjump", 10'(isJump), 10'h1);
        tick();
        chk("beq_ex",   10'(exCtrl), 10'b00100);
        chk("beq_hold", 10'(pcHold), 10'h1);
        drive(RT, ADD, 1'b0);
        tick();
        tick();
        chk("beq_release", 10'(pcHold), 10'h0);

        // Illegal opcode
        drive(6'b111111, ADD, 1'b0);
        tick();
        chk("ill_ex",   10'(exCtrl),    10'b00000);
        chk("ill_flag", 10'(illegalOp), 10'h1);
        drive(RT, ADD, 1'b0);
        tick();
        chk("ill_clear", 10'(illegalOp), 10'h0);
        chk("ill_r_ex",  10'(exCtrl),    10'b00101);

        // JR
        drive(RT, JRF, 1'b0);
        chk("jr_isjump", 10'(isJump), 10'h1);
        tick();
        chk("jr_brsrc", 10'(exCtrl[4:3]), 10'b10);
        chk("jr_hold",  10'(pcHold),      10'h1);
        drive(RT, ADD, 1'b0);
        tick();
        chk("jr_mem", 10'(memCtrl), 10'b001);
        tick();

        // Reset asserted mid-HOLD
        drive(J, ADD, 1'b0);
        tick();
        chk("mid_hold", 10'(pcHold), 10'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_hold", 10'(pcHold),    10'h0);
        chk("mid_rst_ex",   10'(exCtrl),    10'h0);
        chk("mid_rst_mem",  10'(memCtrl),   10'h0);
        chk("mid_rst_wb",   10'(wbCtrl),    10'h0);
        chk("mid_rst_ill",  10'(illegalOp), 10'h0);
        drive(RT, ADD, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_jump", 10'(isJump), 10'h0);
        tick();
        chk("post_rst_ex",   10'(exCtrl), 10'b00101);
        chk("post_rst_hold", 10'(pcHold), 10'h0);

`ifdef DELAY_SLOT_EN
        // J then ADDI in the delay slot
        drive(J, ADD, 1'b0);
        tick();
        drive(ADDI, ADD, 1'b0);
        tick();
        drive(RT, ADD, 1'b0);
        tick();
        chk("ds_bubble", 10'(exCtrl), 10'b00000);
        tick();
        chk("ds_addi_wb", 10'(wbCtrl), 10'b10);
        chk("ds_r_ex",    10'(exCtrl), 10'b00101);

        // J then BNE in the delay slot
        drive(J, ADD, 1'b0);
        tick();
        drive(BNE, ADD, 1'b0);
        chk("ds_bne_nojump", 10'(isJump), 10'h0);
        tick();
        chk("ds_bne_ex",  10'(exCtrl),    10'b00000);
        chk("ds_bne_ill", 10'(illegalOp), 10'h1);
        drive(RT, ADD, 1'b0);
        tick();
        tick();
`else
        drive(BNE, ADD, 1'b0);
        chk("bne_isjump", 10'(isJump), 10'h1);
        tick();
        chk("bne_ex", 10'(exCtrl), 10'b00100);
        drive(RT, ADD, 1'b0);
        tick();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_control_pipe
`default_nettype wire

// File: doc/control_pipe.md
# control_pipe

Parametrised successor to the combinational opcode decoder: decodes `opcode`/`funct` in ID into the 10-bit control word and carries it through registered ID/EX, EX/MEM and MEM/WB control stages. It also owns jump/branch hold sequencing, inserting NOP bubbles and holding the PC until the target is taken. Sits between the instruction register and the hazard detection unit. All opcode constants come from `parameters.v`.

## Interface

Parameters:
- `CONTROL_SIZE`, 10: control word width. Bits are [9:8] branchSrc, [7] AluSrc, [6:5] RegDest, [4] MemRead, [3] MemWrite, [2] Branch, [1] RegWrite, [0] MemToReg.
- `OPCODE_WIDTH`, 6: opcode and funct width.
- `JUMP_DELAY`, 2: bubbles inserted after a jump or branch. Legal range is 1..7.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `opcode`, in, 6: ID-stage opcode.
- `funct`, in, 6: ID-stage funct field (R-type only).
- `stall`, in, 1: load-use stall from hazard detection.
- `exCtrl`, out, 5: ID/EX register, bits [9:5].
- `memCtrl`, out, 3: EX/MEM register, bits [4:2].
- `wbCtrl`, out, 2: MEM/WB register, bits [1:0].
- `isJump`, out, 1: combinational; current ID instruction is an accepted jump or branch.
- `pcHold`, out, 1: freeze PC/IF while in HOLD.
- `illegalOp`, out, 1: registered; unknown opcode was decoded.

## Operation

Decode (combinational):
- R-type (000000): AluSrc=1, RegDest=01, RegWrite=1.
- JR (R-type, funct 001000): branchSrc=10, Branch=1, no RegWrite.
- LW: MemRead=1, RegWrite=1, MemToReg=1, AluSrc=0, RegDest=00.
- SW: MemWrite=1, AluSrc=0.
- BEQ/BNE: branchSrc=00, AluSrc=1, Branch=1.
- J: branchSrc=01, Branch=1.
- JAL: branchSrc=01, Branch=1, RegWrite=1, RegDest=11 (link register $31).
- ADDI/ANDI/ORI/SLTI: AluSrc=0, RegDest=00, RegWrite=1.
- Any other opcode: all-zero word; `illegalOp`=1 on the next edge.

FSM:
- States are RUN and HOLD. There is a 3-bit down-counter `holdCnt`.
- In RUN with Branch=1 and `stall`=0: `isJump`=1, the word is loaded into ID/EX normally, next state is HOLD, and `holdCnt` is set to JUMP_DELAY-1.
- In HOLD: ID/EX loads zeros, `pcHold`=1, and `isJump`=0 regardless of opcode. The FSM leaves for RUN after the cycle with `holdCnt`=0; otherwise it decrements.
- In RUN with `stall`=1: ID/EX loads zeros and the jump is not accepted (`isJump`=0). The same instruction is decoded again next cycle.
- In HOLD, `stall` is ignored.
- EX/MEM and MEM/WB always advance from the previous stage, including during stall and HOLD.

Reset:
- All pipeline registers are zero.
- State is RUN, `holdCnt`=0.
- `illegalOp`=0, `pcHold`=0.
- Reset asserted mid-HOLD aborts the hold immediately.

## Timing

- Decode-to-`exCtrl` latency is 1 edge. `memCtrl` follows at 2 edges, `wbCtrl` at 3.
- `isJump` is valid in the same cycle as `opcode`.
- `pcHold` is high for exactly JUMP_DELAY cycles, starting the cycle after acceptance.
- Back-to-back jumps: a jump in ID during HOLD is squashed. It is re-fetched because the PC was held.

## Configuration

`DELAY_SLOT_EN`:
- Defined: the first HOLD cycle decodes the ID instruction normally (the MIPS delay slot), so bubbles = JUMP_DELAY-1. `pcHold` timing is unchanged. A jump or branch in the delay slot is zeroed and raises `illegalOp`.
- Undefined: every HOLD cycle inserts a bubble.

## Structure

- Control bit indices, RegDest/branchSrc encodings and opcode/funct constants belong in the shared `parameters.v`, alongside `CONTROL_SIZE`.
- One sub-module, `control_decode`: purely combinational opcode/funct to control word plus illegal flag.
- `control_pipe` instantiates it and holds the FSM and stage registers.

## Test plan

- Reset low mid-operation, then release: all outputs 0 and state RUN. LW (100011) next cycle gives `exCtrl`=00000 after 1 edge, `memCtrl`=100 after 2 edges, `wbCtrl`=11 after 3 edges.
- J (000010) with JUMP_DELAY=2: `isJump`=1 that cycle, `pcHold`=1 for 2 cycles, `exCtrl`=0 during those cycles. `memCtrl` shows 001 one edge after the J entered EX.
- LW followed by ADDI with `stall`=1 for one cycle: one all-zero word enters ID/EX, then ADDI gives `exCtrl`=00000 and `wbCtrl`=10 later.
- BEQ presented with `stall`=1: `isJump`=0 and no HOLD. Next cycle with `stall`=0: `isJump`=1 and HOLD entered.
- Opcode 111111: zero control word and `illegalOp`=1 one edge later. JR (funct 001000): `exCtrl`[4:3]=10.
- With `DELAY_SLOT_EN` defined: J then ADDI gives ADDI control in ID/EX on the first HOLD edge and one bubble. J then BNE gives a zero word and `illegalOp`=1.
